// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box extractor and raster helpers.
// Holds coordinate/count widths, the accumulator reset value, the box record and FSM states.
// half_sum() is the floor midpoint used for box centres and temporal smoothing.
package bbox_pkg;

  localparam int COORD_W = 10;
  localparam int CNT_W   = 19;

  // Cleared min accumulators start at the top of the range so the first
  // flagged pixel always wins the compare.
  localparam logic [COORD_W-1:0] COORD_INIT_MIN = 10'h3FF;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
    logic               found;
  } box_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  // (a + b) >> 1 with an 11-bit intermediate so the carry is not lost.
  function automatic logic [COORD_W-1:0] half_sum(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    logic [COORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COORD_W:1];
  endfunction

endpackage

// File: rtl/raster_pos_counter.sv
// Raster position tracker: column/row of the pixel currently on the input, plus end-of-frame.
// Latency: col/row/eof are combinational for the presented pixel; the position state is registered.
// Backpressure: none; advances only on in_valid, in_sof forces the current pixel to (0,0).
// Ports: clk, reset (sync, active-high); in_valid, in_sof -> col, row (current pixel), eof
// (in_valid pixel at the last column of the last row).
module raster_pos_counter
  import bbox_pkg::*;
#(
  parameter int IMG_WIDTH  = 768,
  parameter int IMG_HEIGHT = 576
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_sof,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               eof
);

  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);

  logic [COORD_W-1:0] col_q;
  logic [COORD_W-1:0] row_q;
  logic               sof;

  // A qualified start-of-frame overrides the stored position for this pixel,
  // so the pixel itself is treated as (0,0) and the count continues from there.
  assign sof = in_valid & in_sof;
  assign col = sof ? '0 : col_q;
  assign row = sof ? '0 : row_q;
  assign eof = in_valid && (col == LAST_COL) && (row == LAST_ROW);

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (in_valid) begin
      if (col == LAST_COL) begin
        col_q <= '0;
        row_q <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end else begin
        col_q <= col + 1'b1;
        row_q <= row;
      end
    end
  end

endmodule

// File: rtl/bbox_extract.sv
// Per-frame bounding box of flagged pixels: centre x/y and width/height for the overlay stage.
// Latency: box_valid pulses 2 cycles after the end-of-frame pixel; next frame accumulates meanwhile.
// Backpressure: none; input is a free-running pixel strobe and box_valid is a one-cycle pulse.
// Ports: clk, reset (sync, active-high); in_valid/in_sof/in_mask pixel stream in;
// x, y, width, height, box_found, box_valid out.
// Build option: define BBOX_SMOOTH_EN for a 2-tap temporal average of consecutive found boxes.
module bbox_extract
  import bbox_pkg::*;
#(
  parameter int IMG_WIDTH  = 768,
  parameter int IMG_HEIGHT = 576,
  parameter int MIN_PIXELS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic               in_mask,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] width,
  output logic [COORD_W-1:0] height,
  output logic               box_found,
  output logic               box_valid
);

  logic [COORD_W-1:0] col, row;
  logic               eof;

  raster_pos_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_pos (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_sof  (in_sof),
    .col     (col),
    .row     (row),
    .eof     (eof)
  );

  // Running accumulators and the end-of-frame snapshot.
  logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
  logic [CNT_W-1:0]   cnt;
  logic [COORD_W-1:0] s_min_x, s_max_x, s_min_y, s_max_y;
  logic [CNT_W-1:0]   s_cnt;

  // Accumulator values including the current pixel. A start-of-frame pixel
  // starts from cleared values, which drops any partial frame.
  logic [COORD_W-1:0] n_min_x, n_max_x, n_min_y, n_max_y;
  logic [CNT_W-1:0]   n_cnt;

  always_comb begin
    if (in_valid && in_sof) begin
      n_min_x = COORD_INIT_MIN;
      n_max_x = '0;
      n_min_y = COORD_INIT_MIN;
      n_max_y = '0;
      n_cnt   = '0;
    end else begin
      n_min_x = min_x;
      n_max_x = max_x;
      n_min_y = min_y;
      n_max_y = max_y;
      n_cnt   = cnt;
    end
    if (in_valid && in_mask) begin
      if (col < n_min_x) n_min_x = col;
      if (col > n_max_x) n_max_x = col;
      if (row < n_min_y) n_min_y = row;
      if (row > n_max_y) n_max_y = row;
      if (n_cnt != '1) n_cnt = n_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      min_x   <= COORD_INIT_MIN;
      max_x   <= '0;
      min_y   <= COORD_INIT_MIN;
      max_y   <= '0;
      cnt     <= '0;
      s_min_x <= COORD_INIT_MIN;
      s_max_x <= '0;
      s_min_y <= COORD_INIT_MIN;
      s_max_y <= '0;
      s_cnt   <= '0;
    end else if (eof) begin
      // Snapshot includes the final pixel; accumulators clear so the next
      // frame's first pixel can land on the very next cycle.
      s_min_x <= n_min_x;
      s_max_x <= n_max_x;
      s_min_y <= n_min_y;
      s_max_y <= n_max_y;
      s_cnt   <= n_cnt;
      min_x   <= COORD_INIT_MIN;
      max_x   <= '0;
      min_y   <= COORD_INIT_MIN;
      max_y   <= '0;
      cnt     <= '0;
    end else if (in_valid) begin
      min_x <= n_min_x;
      max_x <= n_max_x;
      min_y <= n_min_y;
      max_y <= n_max_y;
      cnt   <= n_cnt;
    end
  end

  // Box derived from the snapshot; only meaningful while in CALC.
  box_t calc_box, new_box;

  always_comb begin
    calc_box.x      = half_sum(s_min_x, s_max_x);
    calc_box.y      = half_sum(s_min_y, s_max_y);
    calc_box.width  = s_max_x - s_min_x;
    calc_box.height = s_max_y - s_min_y;
    calc_box.found  = (s_cnt >= CNT_W'(MIN_PIXELS));
  end

`ifdef BBOX_SMOOTH_EN
  // Average with the previous published box only when that box was a
  // detection; otherwise the new box loads directly.
  always_comb begin
    new_box = calc_box;
    if (box_found) begin
      new_box.x      = half_sum(x, calc_box.x);
      new_box.y      = half_sum(y, calc_box.y);
      new_box.width  = half_sum(width, calc_box.width);
      new_box.height = half_sum(height, calc_box.height);
    end
  end
`else
  assign new_box = calc_box;
`endif

  state_t state;

  // Outputs are loaded on the CALC->OUT edge so they and box_valid are
  // presented together for the single OUT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      width     <= '0;
      height    <= '0;
      box_found <= 1'b0;
      box_valid <= 1'b0;
    end else begin
      box_valid <= 1'b0;
      case (state)
        IDLE: if (eof) state <= CALC;
        CALC: begin
          state     <= OUT;
          box_valid <= 1'b1;
          box_found <= new_box.found;
          if (new_box.found) begin
            x      <= new_box.x;
            y      <= new_box.y;
            width  <= new_box.width;
            height <= new_box.height;
          end
        end
        OUT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_extract.sv
module tb_bbox_extract;

  localparam int W = 16;
  localparam int H = 8;

  logic clk = 1'b0;
  logic reset, in_valid, in_sof, in_mask;
  logic [9:0] a_x, a_y, a_width, a_height, b_x, b_y, b_width, b_height;
  logic a_box_found, a_box_valid, b_box_found, b_box_valid;

  bbox_extract #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_mask(in_mask),
    .x(a_x), .y(a_y), .width(a_width), .height(a_height),
    .box_found(a_box_found), .box_valid(a_box_valid));

  bbox_extract #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_mask(in_mask),
    .x(b_x), .y(b_y), .width(b_width), .height(b_height),
    .box_found(b_box_found), .box_valid(b_box_valid));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int x, y, w, h;
    bit found;
    int cyc;
  } exp_t;

  exp_t qa[$], qb[$];
  exp_t pa, pb;      // last expected published box per instance
  exp_t ma, mb;      // monitor-side popped entries
  bit mask[H][W];
  int total = 0;
  int bad = 0;

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected publication for one frame given its hand-computed raw box and flag count.
  function automatic exp_t model(input exp_t prev, input int rx, input int ry,
                                 input int rw, input int rh, input int cnt, input int minp);
    exp_t e;
    e = prev;
    if (cnt >= minp) begin
`ifdef BBOX_SMOOTH_EN
      if (prev.found) begin
        e.x = (prev.x + rx) / 2;
        e.y = (prev.y + ry) / 2;
        e.w = (prev.w + rw) / 2;
        e.h = (prev.h + rh) / 2;
      end else begin
        e.x = rx; e.y = ry; e.w = rw; e.h = rh;
      end
`else
      e.x = rx; e.y = ry; e.w = rw; e.h = rh;
`endif
      e.found = 1'b1;
    end else begin
      e.found = 1'b0;
    end
    return e;
  endfunction

  task automatic clear_mask();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) mask[r][c] = 1'b0;
  endtask

  task automatic set_rect(input int c0, input int c1, input int r0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) mask[r][c] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_sof = 1'b0; in_mask = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_mask = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pa = '{default: 0};
    pb = '{default: 0};
  endtask

  // Drives the first npix pixels of the mask; a full frame pushes expectations at EOF.
  // Gap cycles drive junk sof/mask with in_valid low, which must be ignored.
  task automatic send_pixels(input int npix, input bit sof, input bit gaps, input bit push,
                             input int rx, input int ry, input int rw, input int rh, input int cnt);
    for (int i = 0; i < npix; i++) begin
      if (gaps && (i % 7 == 3)) begin
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b1; in_mask = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = sof && (i == 0);
      in_mask  = mask[i / W][i % W];
    end
    if (push) begin
      pa = model(pa, rx, ry, rw, rh, cnt, 1);
      pa.cyc = cyc;
      qa.push_back(pa);
      pb = model(pb, rx, ry, rw, rh, cnt, 4);
      pb.cyc = cyc;
      qb.push_back(pb);
    end
  endtask

  always @(negedge clk) begin
    if (a_box_valid) begin
      if (qa.size() == 0) begin
        cmp("a.unexpected_pulse", 1, 0);
      end else begin
        ma = qa.pop_front();
        cmp("a.latency", cyc - ma.cyc, 2);
        cmp("a.x", a_x, ma.x);
        cmp("a.y", a_y, ma.y);
        cmp("a.width", a_width, ma.w);
        cmp("a.height", a_height, ma.h);
        cmp("a.box_found", a_box_found, ma.found);
      end
    end
    if (b_box_valid) begin
      if (qb.size() == 0) begin
        cmp("b.unexpected_pulse", 1, 0);
      end else begin
        mb = qb.pop_front();
        cmp("b.latency", cyc - mb.cyc, 2);
        cmp("b.x", b_x, mb.x);
        cmp("b.y", b_y, mb.y);
        cmp("b.width", b_width, mb.w);
        cmp("b.height", b_height, mb.h);
        cmp("b.box_found", b_box_found, mb.found);
      end
    end
  end

  task automatic check_zero(input string tag);
    cmp({tag, ".a_x"}, a_x, 0);
    cmp({tag, ".a_y"}, a_y, 0);
    cmp({tag, ".a_width"}, a_width, 0);
    cmp({tag, ".a_height"}, a_height, 0);
    cmp({tag, ".a_found"}, a_box_found, 0);
    cmp({tag, ".a_valid"}, a_box_valid, 0);
    cmp({tag, ".b_x"}, b_x, 0);
    cmp({tag, ".b_found"}, b_box_found, 0);
    cmp({tag, ".b_valid"}, b_box_valid, 0);
  endtask

  initial begin
    int t;
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_mask = 1'b0;
    clear_mask();
    do_reset();
    @(negedge clk);
    check_zero("reset");

    // Single flagged pixel: found only where MIN_PIXELS=1.
    clear_mask(); mask[3][5] = 1'b1;
    send_pixels(W*H, 1, 0, 1, 5, 3, 0, 0, 1);
    idle(4);

    // Rectangle cols 2..9 rows 1..4 with in_valid gaps.
    clear_mask(); set_rect(2, 9, 1, 4);
    send_pixels(W*H, 1, 1, 1, 5, 2, 7, 3, 32);
    idle(4);

    // Three corner-ish pixels: below MIN_PIXELS=4, so dut_b holds the rectangle.
    clear_mask(); mask[7][0] = 1'b1; mask[0][15] = 1'b1; mask[5][8] = 1'b1;
    send_pixels(W*H, 1, 0, 1, 7, 3, 15, 7, 3);
    idle(4);

    // Back-to-back frames; second frame has no sof and flags (0,0) right after EOF.
    do_reset();
    clear_mask(); set_rect(2, 9, 1, 4);
    send_pixels(W*H, 1, 0, 1, 5, 2, 7, 3, 32);
    clear_mask(); mask[0][0] = 1'b1;
    send_pixels(W*H, 0, 0, 1, 0, 0, 0, 0, 1);
    idle(4);

    // Aborted frame with a flag at (1,1); sof at pixel 40 restarts the frame.
    do_reset();
    clear_mask(); mask[1][1] = 1'b1;
    send_pixels(40, 1, 0, 0, 0, 0, 0, 0, 0);
    clear_mask(); mask[6][10] = 1'b1; mask[6][12] = 1'b1;
    send_pixels(W*H, 1, 0, 1, 11, 6, 2, 0, 2);
    idle(4);

    // Reset in the CALC cycle: no pulse and outputs return to zero.
    clear_mask(); set_rect(2, 9, 1, 4);
    send_pixels(W*H, 1, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    idle(6);
    check_zero("calc_reset");

    // Consecutive found boxes x=4 then x=9 (averages to 6 when smoothing is built in).
    clear_mask(); mask[2][4] = 1'b1;
    send_pixels(W*H, 1, 0, 1, 4, 2, 0, 0, 1);
    clear_mask(); mask[2][9] = 1'b1;
    send_pixels(W*H, 1, 0, 1, 9, 2, 0, 0, 1);
    idle(2);

    // Empty frame: nothing found, previous boxes held.
    clear_mask();
    send_pixels(W*H, 1, 0, 1, 0, 0, 0, 0, 0);
    idle(2);

    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    cmp("pending_results", qa.size() + qb.size(), 0);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
